// File: rtl/plic_scan_arbiter.sv
// plic_scan_arbiter
//  Sequential priority resolver for one PLIC target. A single registered
//  compare stage visits one source per clock and keeps the best candidate
//  seen so far; at the end of each scan the winner is published on id_o,
//  priority_o and irq_o, with a one-cycle result_vld_o pulse.
//  Claimed sources are masked out of the scan until they are completed.
//
//  Optional feature macro: PLIC_SCAN_EARLY_EXIT_EN
//   When defined, a scan ends as soon as the best priority reaches the
//   all-ones value. Lower IDs win ties, so the result matches a full scan.
module plic_scan_arbiter #(
   parameter int SOURCES       = 8,
   parameter int PRIORITIES    = 7,
   parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
   parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               en_i,
   input  logic [SOURCES-1:0]                 ip_i,
   input  logic [SOURCES-1:0]                 ie_i,
   input  logic [SOURCES*PRIORITY_BITS-1:0]   ipriority_i,
   input  logic [PRIORITY_BITS-1:0]           threshold_i,
   input  logic                               claim_i,
   input  logic                               complete_i,
   input  logic [SOURCES_BITS-1:0]            complete_id_i,
   output logic [SOURCES_BITS-1:0]            id_o,
   output logic [PRIORITY_BITS-1:0]           priority_o,
   output logic                               irq_o,
   output logic                               result_vld_o,
   output logic                               busy_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   localparam logic [SOURCES_BITS-1:0]  ID_NONE  = {SOURCES_BITS{1'b0}};
   localparam logic [SOURCES_BITS-1:0]  ID_FIRST = SOURCES_BITS'(1);
   localparam logic [SOURCES_BITS-1:0]  ID_LAST  = SOURCES_BITS'(SOURCES);
   localparam logic [PRIORITY_BITS-1:0] PRI_ZERO = {PRIORITY_BITS{1'b0}};
   localparam logic [PRIORITY_BITS-1:0] PRI_MAX  = {PRIORITY_BITS{1'b1}};

   logic [0:0]               state_r;
   logic [SOURCES_BITS-1:0]  idx_r;
   logic [SOURCES_BITS-1:0]  best_id_r;
   logic [PRIORITY_BITS-1:0] best_pri_r;
   logic [SOURCES-1:0]       claimed_r;     // bit i-1 = source i
   logic [SOURCES_BITS-1:0]  id_r;
   logic [PRIORITY_BITS-1:0] priority_r;
   logic                     irq_r;
   logic                     result_vld_r;

   logic                     cur_ip_s;
   logic                     cur_ie_s;
   logic                     cur_claimed_s;
   logic [PRIORITY_BITS-1:0] cur_pri_s;
   logic                     candidate_s;
   logic [SOURCES_BITS-1:0]  next_best_id_s;
   logic [PRIORITY_BITS-1:0] next_best_pri_s;
   logic                     scan_last_s;
   logic                     claim_ok_s;
   logic [SOURCES-1:0]       claim_mask_s;
   logic [SOURCES-1:0]       complete_mask_s;
   logic [SOURCES-1:0]       claimed_next_s;

   assign id_o         = id_r;
   assign priority_o   = priority_r;
   assign irq_o        = irq_r;
   assign result_vld_o = result_vld_r;
   assign busy_o       = (state_r == ST_SCAN);

   // Pick out the pending/enable/claimed/priority of the source under the scan index.
   always_comb begin
      cur_ip_s      = 1'b0;
      cur_ie_s      = 1'b0;
      cur_claimed_s = 1'b0;
      cur_pri_s     = PRI_ZERO;
      for (int i = 0; i < SOURCES; i++) begin
         cur_ip_s      = cur_ip_s      | (ip_i[i]      & (idx_r == SOURCES_BITS'(i + 1)));
         cur_ie_s      = cur_ie_s      | (ie_i[i]      & (idx_r == SOURCES_BITS'(i + 1)));
         cur_claimed_s = cur_claimed_s | (claimed_r[i] & (idx_r == SOURCES_BITS'(i + 1)));
         cur_pri_s     = cur_pri_s
                       | (ipriority_i[i*PRIORITY_BITS +: PRIORITY_BITS]
                          & {PRIORITY_BITS{idx_r == SOURCES_BITS'(i + 1)}});
      end
   end

   // Compare the current source against the running best; strict > keeps lower IDs on ties.
   always_comb begin
      candidate_s = cur_ip_s & cur_ie_s & ~cur_claimed_s & (cur_pri_s > best_pri_r);
      if (candidate_s) begin
         next_best_id_s  = idx_r;
         next_best_pri_s = cur_pri_s;
      end else begin
         next_best_id_s  = best_id_r;
         next_best_pri_s = best_pri_r;
      end
`ifdef PLIC_SCAN_EARLY_EXIT_EN
      scan_last_s = (idx_r == ID_LAST) | (next_best_pri_s == PRI_MAX);
`else
      scan_last_s = (idx_r == ID_LAST);
`endif
   end

   // Next claimed mask: completes clear only claimed bits, a claim of the same ID wins.
   always_comb begin
      claim_ok_s = claim_i & (id_r != ID_NONE);
      for (int i = 0; i < SOURCES; i++) begin
         claim_mask_s[i]    = claim_ok_s & (id_r == SOURCES_BITS'(i + 1));
         complete_mask_s[i] = complete_i & claimed_r[i]
                            & (complete_id_i == SOURCES_BITS'(i + 1));
      end
      claimed_next_s = (claimed_r & ~complete_mask_s) | claim_mask_s;
   end

   // Scan FSM, running best, published result and claimed mask.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         idx_r        <= ID_FIRST;
         best_id_r    <= ID_NONE;
         best_pri_r   <= PRI_ZERO;
         claimed_r    <= {SOURCES{1'b0}};
         id_r         <= ID_NONE;
         priority_r   <= PRI_ZERO;
         irq_r        <= 1'b0;
         result_vld_r <= 1'b0;
      end else begin
         claimed_r    <= claimed_next_s;
         result_vld_r <= 1'b0;
         // A successful claim retires the published winner immediately.
         if (claim_ok_s) begin
            id_r       <= ID_NONE;
            priority_r <= PRI_ZERO;
            irq_r      <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (en_i) begin
                  state_r    <= ST_SCAN;
                  idx_r      <= ID_FIRST;
                  best_id_r  <= ID_NONE;
                  best_pri_r <= PRI_ZERO;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (!en_i) begin
                  // Abandon the scan; published outputs hold.
                  state_r <= ST_IDLE;
               end else if (claim_ok_s) begin
                  // Rescan from the top so the new mask is seen everywhere.
                  idx_r      <= ID_FIRST;
                  best_id_r  <= ID_NONE;
                  best_pri_r <= PRI_ZERO;
               end else if (scan_last_s) begin
                  id_r         <= next_best_id_s;
                  priority_r   <= next_best_pri_s;
                  irq_r        <= (next_best_pri_s > threshold_i);
                  result_vld_r <= 1'b1;
                  idx_r        <= ID_FIRST;
                  best_id_r    <= ID_NONE;
                  best_pri_r   <= PRI_ZERO;
               end else begin
                  idx_r      <= idx_r + SOURCES_BITS'(1);
                  best_id_r  <= next_best_id_s;
                  best_pri_r <= next_best_pri_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= ID_FIRST;
            end
         endcase
      end
   end

endmodule
